// File: rtl/circ_frame_delay.sv
// CIRC frame-delay stage: delays a selectable subset of words per frame
// by DELAY accepted frames, carrying a per-word erasure flag.
//
// Ports:
//   CLK      clock, all state on posedge
//   RST      asynchronous active-high reset
//   MODE     0: delay words with DELAY_MASK=1, 1: delay words with DELAY_MASK=0
//   D_VALID  frame strobe, one frame accepted per high cycle
//   D/D_ERA  input frame words and erasure flags
//   Q/Q_ERA  registered output frame words and erasure flags
//   Q_VALID  one-cycle pulse per output frame
//   PRIMED   delay line holds DELAY frames of the current mode
module circ_frame_delay #(
    parameter int WIDTH = 8,
    parameter int WORDS = 24,
    parameter int DELAY = 2,
    parameter logic [WORDS-1:0] DELAY_MASK = 24'hF0F0F0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         MODE,
    input  logic                         D_VALID,
    input  logic [WORDS-1:0][WIDTH-1:0]  D,
    input  logic [WORDS-1:0]             D_ERA,
    output logic [WORDS-1:0][WIDTH-1:0]  Q,
    output logic [WORDS-1:0]             Q_ERA,
    output logic                         Q_VALID,
    output logic                         PRIMED
);

    localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int CW = $clog2(DELAY + 1);

    // Delay line; contents are only trusted once cnt reaches DELAY.
    logic [WORDS-1:0][WIDTH-1:0] mem_d [DELAY];
    logic [WORDS-1:0]            mem_e [DELAY];

    logic [PW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          last_mode;

    logic [CW-1:0]               cnt_eff;
    logic [CW-1:0]               cnt_nxt;
    logic                        hit;
    logic [WORDS-1:0]            em;
    logic [WORDS-1:0][WIDTH-1:0] rd_d;
    logic [WORDS-1:0]            rd_e;
    logic [WORDS-1:0][WIDTH-1:0] q_n;
    logic [WORDS-1:0]            e_n;
    logic [PW-1:0]               wptr_nxt;

    always_comb begin
        // A mode change restarts priming from this frame.
        cnt_eff  = (MODE != last_mode) ? '0 : cnt;
        hit      = (cnt_eff == CW'(DELAY));
        cnt_nxt  = hit ? cnt_eff : cnt_eff + 1'b1;
        em       = MODE ? ~DELAY_MASK : DELAY_MASK;
        rd_d     = mem_d[wptr];
        rd_e     = mem_e[wptr];
        wptr_nxt = (wptr == PW'(DELAY - 1)) ? '0 : wptr + 1'b1;
        q_n      = '0;
        e_n      = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (!em[k]) begin
                q_n[k] = D[k];
                e_n[k] = D_ERA[k];
            end else if (hit) begin
                q_n[k] = rd_d[k];
                e_n[k] = rd_e[k];
            end else begin
                q_n[k] = '0;
                e_n[k] = 1'b1;
            end
        end
    end

    // Buffer is not reset; a frame strobed during reset is dropped.
    always_ff @(posedge CLK) begin
        if (D_VALID && !RST) begin
            mem_d[wptr] <= D;
            mem_e[wptr] <= D_ERA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q         <= '0;
            Q_ERA     <= '0;
            Q_VALID   <= 1'b0;
            PRIMED    <= 1'b0;
            wptr      <= '0;
            cnt       <= '0;
            last_mode <= 1'b0;
        end else begin
            Q_VALID <= D_VALID;
            if (D_VALID) begin
                Q         <= q_n;
                Q_ERA     <= e_n;
                PRIMED    <= hit;
                wptr      <= wptr_nxt;
                cnt       <= cnt_nxt;
                last_mode <= MODE;
            end
        end
    end

endmodule

// File: tb/tb_circ_frame_delay.sv
// Scoreboard bench for circ_frame_delay at DELAY=2, 5 and 1 sharing
// one stimulus stream; reference model works on a frame history.
module tb_circ_frame_delay;

    localparam int WIDTH = 8;
    localparam int WORDS = 24;
    localparam logic [WORDS-1:0] MASK = 24'hF0F0F0;
    localparam int ND = 3;

    typedef logic [WORDS-1:0][WIDTH-1:0] frm_t;
    typedef struct {
        frm_t             d;
        logic [WORDS-1:0] e;
    } hist_t;
    typedef struct {
        frm_t             q;
        logic [WORDS-1:0] era;
        logic             primed;
    } exp_t;

    int dl [ND] = '{2, 5, 1};

    logic             CLK = 1'b0;
    logic             RST;
    logic             MODE;
    logic             D_VALID;
    frm_t             D;
    logic [WORDS-1:0] D_ERA;

    frm_t             qa  [ND];
    logic [WORDS-1:0] qea [ND];
    logic             qva [ND];
    logic             pa  [ND];

    circ_frame_delay #(.WIDTH(WIDTH), .WORDS(WORDS), .DELAY(2),
                       .DELAY_MASK(MASK)) u_d2 (
        .CLK(CLK), .RST(RST), .MODE(MODE), .D_VALID(D_VALID),
        .D(D), .D_ERA(D_ERA), .Q(qa[0]), .Q_ERA(qea[0]),
        .Q_VALID(qva[0]), .PRIMED(pa[0]));

    circ_frame_delay #(.WIDTH(WIDTH), .WORDS(WORDS), .DELAY(5),
                       .DELAY_MASK(MASK)) u_d5 (
        .CLK(CLK), .RST(RST), .MODE(MODE), .D_VALID(D_VALID),
        .D(D), .D_ERA(D_ERA), .Q(qa[1]), .Q_ERA(qea[1]),
        .Q_VALID(qva[1]), .PRIMED(pa[1]));

    circ_frame_delay #(.WIDTH(WIDTH), .WORDS(WORDS), .DELAY(1),
                       .DELAY_MASK(MASK)) u_d1 (
        .CLK(CLK), .RST(RST), .MODE(MODE), .D_VALID(D_VALID),
        .D(D), .D_ERA(D_ERA), .Q(qa[2]), .Q_ERA(qea[2]),
        .Q_VALID(qva[2]), .PRIMED(pa[2]));

    always #5 CLK = ~CLK;

    int    errors = 0;
    int    checks = 0;
    exp_t  expq [ND][$];
    exp_t  last [ND];
    hist_t hist [$];
    int    seg = 0;
    logic  lm = 1'b0;

    task automatic cmp(input int i, input string nm, input exp_t x);
        checks++;
        if (qa[i] !== x.q || qea[i] !== x.era || pa[i] !== x.primed) begin
            errors++;
            $display("FAIL %s dly=%0d t=%0t: Q=%h ERA=%h P=%b, want Q=%h ERA=%h P=%b",
                     nm, dl[i], $time, qa[i], qea[i], pa[i],
                     x.q, x.era, x.primed);
        end
    endtask

    // Delayed words take the frame accepted dl frames ago once dl frames
    // of the current mode have been seen; otherwise they are fill.
    task automatic model(input frm_t d, input logic [WORDS-1:0] e,
                         input logic m);
        logic [WORDS-1:0] em;
        exp_t x;
        hist_t h;
        if (m != lm) begin
            seg = 0;
            lm  = m;
        end
        em = m ? ~MASK : MASK;
        for (int i = 0; i < ND; i++) begin
            x.primed = (seg >= dl[i]);
            if (x.primed) h = hist[hist.size() - dl[i]];
            for (int k = 0; k < WORDS; k++) begin
                if (!em[k]) begin
                    x.q[k]   = d[k];
                    x.era[k] = e[k];
                end else if (x.primed) begin
                    x.q[k]   = h.d[k];
                    x.era[k] = h.e[k];
                end else begin
                    x.q[k]   = '0;
                    x.era[k] = 1'b1;
                end
            end
            expq[i].push_back(x);
        end
        h.d = d;
        h.e = e;
        hist.push_back(h);
        if (hist.size() > 8) void'(hist.pop_front());
        seg++;
    endtask

    always @(negedge CLK) begin
        exp_t x;
        for (int i = 0; i < ND; i++) begin
            if (qva[i] === 1'b1) begin
                if (expq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dly=%0d t=%0t: Q_VALID=1, want 0",
                             dl[i], $time);
                end else begin
                    x = expq[i].pop_front();
                    cmp(i, "frame", x);
                    last[i] = x;
                end
            end else if (!RST) begin
                cmp(i, "hold", last[i]);
            end
        end
    end

    function automatic frm_t pat(input int n);
        frm_t f;
        for (int k = 0; k < WORDS; k++) f[k] = WIDTH'((n * 32 + k) % 256);
        return f;
    endfunction

    function automatic frm_t rnd();
        frm_t f;
        for (int k = 0; k < WORDS; k++) f[k] = WIDTH'($urandom);
        return f;
    endfunction

    task automatic send(input frm_t d, input logic [WORDS-1:0] e,
                        input logic m);
        D       = d;
        D_ERA   = e;
        MODE    = m;
        D_VALID = 1'b1;
        model(d, e, m);
        @(posedge CLK);
        #1;
        D_VALID = 1'b0;
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            D     = rnd();
            D_ERA = WORDS'($urandom);
            MODE  = 1'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    // Asynchronous reset away from any clock edge, then one strobe that
    // lands while reset is held and must be dropped.
    task automatic do_reset();
        exp_t z;
        z.q = '0;
        z.era = '0;
        z.primed = 1'b0;
        RST = 1'b1;
        #2;
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (qa[i] !== '0 || qea[i] !== '0 || qva[i] !== 1'b0 || pa[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dly=%0d: Q=%h ERA=%h V=%b P=%b, want all 0",
                         dl[i], qa[i], qea[i], qva[i], pa[i]);
            end
            expq[i].delete();
            last[i] = z;
        end
        hist.delete();
        seg = 0;
        lm  = 1'b0;
        D       = rnd();
        D_ERA   = '0;
        MODE    = 1'b1;
        D_VALID = 1'b1;
        @(posedge CLK);
        #1;
        D_VALID = 1'b0;
        RST = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        logic [WORDS-1:0] e;
        RST     = 1'b1;
        MODE    = 1'b0;
        D_VALID = 1'b0;
        D       = '0;
        D_ERA   = '0;
        for (int i = 0; i < ND; i++) begin
            last[i].q = '0;
            last[i].era = '0;
            last[i].primed = 1'b0;
        end
        #12;
        do_reset();

        for (int n = 0; n < 5; n++) send(pat(n), '0, 1'b0);
        idle(2);
        do_reset();

        for (int n = 0; n < 4; n++) begin
            send(pat(n), '0, 1'b0);
            idle(3);
        end
        do_reset();

        for (int n = 0; n < 8; n++) send(pat(n), '0, n >= 4);
        idle(2);
        do_reset();

        for (int n = 0; n < 7; n++) begin
            e = '0;
            if (n == 3) begin
                e[5] = 1'b1;
                e[0] = 1'b1;
            end
            send(pat(n), e, 1'b0);
        end
        idle(1);
        do_reset();

        for (int n = 0; n < 12; n++) send(pat(n), '0, 1'b0);
        do_reset();
        for (int n = 0; n < 3; n++) send(pat(n + 100), '0, 1'b0);
        idle(2);

        m = 1'b0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(7) == 0) m = ~m;
            send(rnd(), WORDS'($urandom), m);
            if ($urandom_range(1) == 0) idle($urandom_range(3, 1));
            if ($urandom_range(99) == 0) do_reset();
        end
        idle(3);

        for (int i = 0; i < ND; i++) begin
            checks++;
            if (expq[i].size() != 0) begin
                errors++;
                $display("FAIL drain dly=%0d: %0d frames outstanding, want 0",
                         dl[i], expq[i].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
